// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ripple-carry ALU: latches one
// operation, holds the ALU inputs for a settle window, then returns the result.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_over,
  input  logic        alu_zero,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_over,
  output logic        rsp_zero,

  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(3);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic              op_id;
  logic [CNT_W-1:0]  cnt;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              capture;
  logic              cap_carry;
  logic              cap_over;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant; the loser of a tie is whoever was served last
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        if (grant0 || grant1) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) begin
      state_next = ST_IDLE;
      grant0     = 1'b0;
      grant1     = 1'b0;
      capture    = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  // Only arithmetic ops carry meaningful flags; SLT keeps overflow only
  always_comb begin
    cap_carry = 1'b0;
    cap_over  = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        cap_carry = alu_carry;
        cap_over  = alu_over;
      end
      OP_SLT: begin
        cap_over = alu_over;
      end
      default: begin
        cap_carry = 1'b0;
        cap_over  = 1'b0;
      end
    endcase
  end

  // Operand latch and settle counter; alu_* keep the last op to avoid toggling
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else if (accept) begin
      alu_a      <= grant1 ? req1_a  : req0_a;
      alu_b      <= grant1 ? req1_b  : req0_b;
      alu_op     <= grant1 ? req1_op : req0_op;
      op_id      <= grant1;
      last_grant <= grant1;
      cnt        <= '0;
    end else if (state == ST_SETTLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Response channel: fields only change at capture, so they hold through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_over   <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      rsp_valid <= (state_next == ST_RESP);
      busy      <= (state_next != ST_IDLE);
      if (capture) begin
        rsp_id     <= op_id;
        rsp_result <= DATA_W'(alu_out);
        rsp_carry  <= cap_carry;
        rsp_over   <= cap_over;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;

  localparam int unsigned S = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_carry, alu_over, alu_zero;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_over, rsp_zero, busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [35:0] exp_q[$];
  int          acc_q[$];
  bit          rsp_seen = 0;
  bit          rdy0_prev = 0, rdy1_prev = 0;

  alu_arbiter #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_over(alu_over), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_over(rsp_over),
    .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: raw carry/overflow come from the adder for every op, so masking is observable
  logic [32:0] m_sum;
  logic [31:0] m_b;
  logic        m_sub;
  always_comb begin
    m_sub     = (alu_op == OP_SUB) || (alu_op == OP_SLT);
    m_b       = m_sub ? ~alu_b : alu_b;
    m_sum     = {1'b0, alu_a} + {1'b0, m_b} + 33'(m_sub);
    alu_carry = m_sum[32];
    alu_over  = (alu_a[31] == m_b[31]) && (m_sum[31] != alu_a[31]);
    case (alu_op)
      OP_ADD, OP_SUB: alu_out = m_sum[31:0];
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_SLT:  alu_out = {31'd0, m_sum[31] ^ alu_over};
      OP_AND:  alu_out = alu_a & alu_b;
      OP_NAND: alu_out = ~(alu_a & alu_b);
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a | alu_b;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  function automatic logic [35:0] pk(input bit id, input logic [31:0] r,
                                     input bit c, input bit o, input bit z);
    return {id, r, c, o, z};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: accept timestamps, latency, response contents, ready pulse width
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      rsp_seen  = 0;
      rdy0_prev = 0;
      rdy1_prev = 0;
    end else begin
      if (rdy0_prev) chk("req0_ready single pulse", 64'(req0_ready), 64'd0);
      if (rdy1_prev) chk("req1_ready single pulse", 64'(req1_ready), 64'd0);
      rdy0_prev = req0_ready;
      rdy1_prev = req1_ready;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
        acc_q.push_back(cyc + 1);
      if (rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          if (acc_q.size() == 0) flag_fail("response without accept");
          else chk("accept to rsp_valid latency", 64'(cyc), 64'(acc_q.pop_front() + S));
        end
        if (exp_q.size() == 0) begin
          flag_fail("unexpected response");
        end else begin
          chk("rsp id/result/carry/over/zero",
              64'({rsp_id, rsp_result, rsp_carry, rsp_over, rsp_zero}), 64'(exp_q[0]));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    bit done = 0;
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) done = 1;
    end
    if (!done) flag_fail($sformatf("req%0d accept timeout", n));
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !rsp_valid && !busy;
    end
    if (!idle) flag_fail("drain timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset values with no requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req0_ready", 64'(req0_ready), 64'd0);
    chk("reset req1_ready", 64'(req1_ready), 64'd0);
    chk("reset alu_a", 64'(alu_a), 64'd0);
    chk("reset alu_b", 64'(alu_b), 64'd0);
    chk("reset alu_op", 64'(alu_op), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester, arithmetic and SLT flag handling
    exp_q.push_back(pk(0, 32'd11, 0, 0, 0));
    issue(0, 32'd10, 32'd1, OP_ADD);
    @(negedge clk);
    chk("busy during settle", 64'(busy), 64'd1);
    chk("alu_a latched", 64'(alu_a), 64'd10);
    chk("alu_op latched", 64'(alu_op), 64'(OP_ADD));
    wait_idle();
    chk("alu_a held after completion", 64'(alu_a), 64'd10);
    exp_q.push_back(pk(0, 32'h8000_0000, 0, 1, 0));
    issue(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    wait_idle();
    exp_q.push_back(pk(1, 32'd1, 0, 1, 0));
    issue(1, 32'h8000_0000, 32'd1, OP_SLT);
    wait_idle();

    // Simultaneous requests right after reset: req0 first
    do_reset(1);
    exp_q.push_back(pk(0, 32'hFFFF_FFFF, 0, 0, 0));
    exp_q.push_back(pk(1, 32'd0, 0, 0, 1));
    fork
      issue(0, 32'd0, 32'd1, OP_SUB);
      issue(1, 32'd1, 32'd1, OP_XOR);
    join
    wait_idle();

    // Both held valid back to back: strict alternation 0,1,0,1
    exp_q.push_back(pk(0, 32'd0, 1, 0, 1));
    exp_q.push_back(pk(1, 32'h7FFF_FFFF, 1, 1, 0));
    exp_q.push_back(pk(0, 32'h8000_0000, 0, 0, 0));
    exp_q.push_back(pk(1, 32'hF000_F000, 0, 0, 0));
    fork
      begin
        issue(0, 32'hFFFF_FFFF, 32'd1, OP_ADD);
        issue(0, 32'hFFFF_FFFF, 32'h8000_0000, OP_AND);
      end
      begin
        issue(1, 32'h8000_0000, 32'd1, OP_SUB);
        issue(1, 32'h0F0F_0F0F, 32'h00FF_00FF, OP_NOR);
      end
    join
    wait_idle();

    // Back-pressure: response held, no new grant until it is taken
    rsp_ready = 1'b0;
    exp_q.push_back(pk(1, 32'd0, 0, 0, 1));
    exp_q.push_back(pk(0, 32'h1234_5678, 0, 0, 0));
    issue(1, 32'd2, 32'd1, OP_SLT);
    fork
      issue(0, 32'h1234_0000, 32'h0000_5678, OP_OR);
    join_none
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) flag_fail("stalled response never appeared");
    repeat (5) begin
      @(negedge clk);
      chk("req0_ready while rsp stalled", 64'(req0_ready), 64'd0);
      chk("rsp_valid while stalled", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait fork;
    wait_idle();

    // Reset during settle aborts the op; grant pointer restarts at req0
    issue(0, 32'h5555_5555, 32'h0000_0001, OP_ADD);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("alu_a cleared by reset", 64'(alu_a), 64'd0);
    chk("busy cleared by reset", 64'(busy), 64'd0);
    repeat (S + 4) begin
      @(negedge clk);
      chk("no response after abort", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pk(0, 32'd0, 0, 0, 1));
    exp_q.push_back(pk(1, 32'd12, 0, 0, 0));
    fork
      issue(1, 32'd5, 32'd7, OP_ADD);
      issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_NAND);
    join
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
